// File: rtl/main_controller.sv
// Multicycle MIPS main control unit.
// Moore FSM that walks each instruction through fetch, decode, execute, memory
// and writeback, and drives every datapath enable and mux select from the state.
// The outputs are registered, and each one is decoded from the next state.
// Optional feature: define MAIN_CTRL_ADDI_EN to add the addi path (states 9/10).
module main_controller (
   input  logic       clk,
   input  logic       reset,
   input  logic [5:0] op,
   output logic [1:0] aluop,
   output logic       alusrca,
   output logic [1:0] alusrcb,
   output logic [1:0] pcsrc,
   output logic       iord,
   output logic       irwrite,
   output logic       memwrite,
   output logic       regwrite,
   output logic       regdst,
   output logic       memtoreg,
   output logic       pcwrite,
   output logic       branch,
   output logic [3:0] state
);

   localparam logic [5:0] OpLw    = 6'b100011;
   localparam logic [5:0] OpSw    = 6'b101011;
   localparam logic [5:0] OpRtype = 6'b000000;
   localparam logic [5:0] OpBeq   = 6'b000100;
   localparam logic [5:0] OpJ     = 6'b000010;
`ifdef MAIN_CTRL_ADDI_EN
   localparam logic [5:0] OpAddi  = 6'b001000;
`endif

   typedef enum logic [3:0] {
      StFetch   = 4'd0,
      StDecode  = 4'd1,
      StMemAdr  = 4'd2,
      StMemRd   = 4'd3,
      StMemWb   = 4'd4,
      StMemWr   = 4'd5,
      StExecute = 4'd6,
      StAluWb   = 4'd7,
      StBranch  = 4'd8,
`ifdef MAIN_CTRL_ADDI_EN
      StAddiEx  = 4'd9,
      StAddiWb  = 4'd10,
`endif
      StJump    = 4'd11
   } state_t;

   typedef struct packed {
      logic [1:0] aluop;
      logic       alusrca;
      logic [1:0] alusrcb;
      logic [1:0] pcsrc;
      logic       iord;
      logic       irwrite;
      logic       memwrite;
      logic       regwrite;
      logic       regdst;
      logic       memtoreg;
      logic       pcwrite;
      logic       branch;
   } ctrl_t;

   state_t state_q, state_d;
   ctrl_t  ctrl_q;

   // Control word asserted in each state; unused encodings decode to all zeros.
   function automatic ctrl_t decode(input logic [3:0] s);
      ctrl_t c;
      c = '0;
      case (s)
         4'd0: begin c.irwrite = 1'b1; c.pcwrite = 1'b1; c.alusrcb = 2'b01; end
         4'd1: c.alusrcb = 2'b11;
         4'd2: begin c.alusrca = 1'b1; c.alusrcb = 2'b10; end
         4'd3: c.iord = 1'b1;
         4'd4: begin c.regwrite = 1'b1; c.memtoreg = 1'b1; end
         4'd5: begin c.iord = 1'b1; c.memwrite = 1'b1; end
         4'd6: begin c.alusrca = 1'b1; c.aluop = 2'b10; end
         4'd7: begin c.regwrite = 1'b1; c.regdst = 1'b1; end
         4'd8: begin
            c.alusrca = 1'b1;
            c.aluop   = 2'b01;
            c.pcsrc   = 2'b01;
            c.branch  = 1'b1;
         end
`ifdef MAIN_CTRL_ADDI_EN
         4'd9:  begin c.alusrca = 1'b1; c.alusrcb = 2'b10; end
         4'd10: c.regwrite = 1'b1;
`endif
         4'd11: begin c.pcwrite = 1'b1; c.pcsrc = 2'b10; end
         default: c = '0;
      endcase
      return c;
   endfunction

   // Next-state logic; op is only consulted in DECODE and MEMADR.
   always_comb begin
      state_d = StFetch;
      case (state_q)
         StFetch:  state_d = StDecode;
         StDecode: begin
            case (op)
               OpLw, OpSw: state_d = StMemAdr;
               OpRtype:    state_d = StExecute;
               OpBeq:      state_d = StBranch;
`ifdef MAIN_CTRL_ADDI_EN
               OpAddi:     state_d = StAddiEx;
`endif
               OpJ:        state_d = StJump;
               default:    state_d = StFetch;  // illegal opcode runs as a no-op
            endcase
         end
         StMemAdr:  state_d = (op == OpLw) ? StMemRd : StMemWr;
         StMemRd:   state_d = StMemWb;
         StExecute: state_d = StAluWb;
`ifdef MAIN_CTRL_ADDI_EN
         StAddiEx:  state_d = StAddiWb;
`endif
         default:   state_d = StFetch;  // terminal and unused states
      endcase
   end

   // State register plus outputs pre-decoded from the next state; reset wins.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= StFetch;
         ctrl_q  <= decode(4'd0);
      end else begin
         state_q <= state_d;
         ctrl_q  <= decode(state_d);
      end
   end

   assign state    = state_q;
   assign aluop    = ctrl_q.aluop;
   assign alusrca  = ctrl_q.alusrca;
   assign alusrcb  = ctrl_q.alusrcb;
   assign pcsrc    = ctrl_q.pcsrc;
   assign iord     = ctrl_q.iord;
   assign irwrite  = ctrl_q.irwrite;
   assign memwrite = ctrl_q.memwrite;
   assign regwrite = ctrl_q.regwrite;
   assign regdst   = ctrl_q.regdst;
   assign memtoreg = ctrl_q.memtoreg;
   assign pcwrite  = ctrl_q.pcwrite;
   assign branch   = ctrl_q.branch;

endmodule
